// File: rtl/ram_fifo_ctrl_if.sv
// Writer/reader stream bundle for ram_fifo_ctrl: push side (WR_*) and
// first-word-fall-through pop side (RD_*).
interface ram_fifo_ctrl_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  WR_REQ;
   logic [DATA_WIDTH-1:0] WR_DAT;
   logic                  WR_FULL;
   logic                  RD_VALID;
   logic [DATA_WIDTH-1:0] RD_DAT;
   logic                  RD_READY;

   modport master (
      output WR_REQ, WR_DAT, RD_READY,
      input  WR_FULL, RD_VALID, RD_DAT
   );

   modport slave (
      input  WR_REQ, WR_DAT, RD_READY,
      output WR_FULL, RD_VALID, RD_DAT
   );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FWFT FIFO controller around an external simple dual-port RAM with registered read.
// Optional sticky overflow flag enabled by defining RAM_FIFO_OVF_EN.
module ram_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADR_WIDTH  = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   ram_fifo_ctrl_if.slave        bus,
   output logic [ADR_WIDTH:0]    LEVEL,
   output logic                  OVF,
   input  logic                  OVF_CLR,
   output logic                  RAM_WEN,
   output logic [ADR_WIDTH-1:0]  RAM_WADR,
   output logic [DATA_WIDTH-1:0] RAM_WDAT,
   output logic [ADR_WIDTH-1:0]  RAM_RADR,
   input  logic [DATA_WIDTH-1:0] RAM_RDAT
);
   localparam logic [ADR_WIDTH:0] DEPTH_L = {1'b1, {ADR_WIDTH{1'b0}}};

   logic [ADR_WIDTH:0]    wptr;
   logic [ADR_WIDTH:0]    rptr;
   logic                  full;
   logic                  wr_acc;
   logic                  consume;
   logic                  issue;
   logic                  inflight_p1;
   logic                  out_vld_p2;
   logic [DATA_WIDTH-1:0] out_dat_p2;
   logic                  skid_vld_p2;
   logic [DATA_WIDTH-1:0] skid_dat_p2;
   logic [2:0]            load;
   logic                  out_ld;
   logic                  skid_ld;
   logic [DATA_WIDTH-1:0] out_nxt;

   assign LEVEL   = wptr - rptr;
   assign full    = (LEVEL == DEPTH_L);
   assign wr_acc  = bus.WR_REQ & ~full & ~RST;
   assign consume = out_vld_p2 & bus.RD_READY;

   // Occupancy of the prefetch path after this cycle's pop must leave room for one more word.
   assign load  = {2'b00, out_vld_p2} + {2'b00, skid_vld_p2} + {2'b00, inflight_p1};
   assign issue = (LEVEL != '0) && (load <= ({2'b00, consume} + 3'd1));

   assign RAM_WEN  = wr_acc;
   assign RAM_WADR = wptr[ADR_WIDTH-1:0];
   assign RAM_WDAT = bus.WR_DAT;
   assign RAM_RADR = rptr[ADR_WIDTH-1:0];

   assign bus.WR_FULL  = full;
   assign bus.RD_VALID = out_vld_p2;
   assign bus.RD_DAT   = out_dat_p2;

   // Skid word always drains into the output register before fresh RAM data.
   assign out_ld  = consume ? (skid_vld_p2 | inflight_p1) : (inflight_p1 & ~out_vld_p2);
   assign skid_ld = inflight_p1 & (consume ? skid_vld_p2 : out_vld_p2);
   assign out_nxt = (consume & skid_vld_p2) ? skid_dat_p2 : RAM_RDAT;

   // p0 -> p1: pointer update and read issue
   always_ff @(posedge CLK) begin
      if (RST) begin
         wptr        <= '0;
         rptr        <= '0;
         inflight_p1 <= 1'b0;
      end else begin
         if (wr_acc) wptr <= wptr + 1'b1;
         if (issue)  rptr <= rptr + 1'b1;
         inflight_p1 <= issue;
      end
   end

   // p1 -> p2: capture RAM read data into output / skid registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         out_vld_p2  <= 1'b0;
         skid_vld_p2 <= 1'b0;
         out_dat_p2  <= '0;
      end else begin
         out_vld_p2  <= consume ? (skid_vld_p2 | inflight_p1) : (out_vld_p2 | inflight_p1);
         skid_vld_p2 <= consume ? (skid_vld_p2 & inflight_p1) : (skid_vld_p2 | (inflight_p1 & out_vld_p2));
         if (out_ld) out_dat_p2 <= out_nxt;
      end
   end

   always_ff @(posedge CLK) begin
      if (skid_ld) skid_dat_p2 <= RAM_RDAT;
   end

`ifdef RAM_FIFO_OVF_EN
   logic ovf_q;

   always_ff @(posedge CLK) begin
      if (RST)                     ovf_q <= 1'b0;
      else if (bus.WR_REQ & full)  ovf_q <= 1'b1;
      else if (OVF_CLR)            ovf_q <= 1'b0;
   end

   assign OVF = ovf_q;
`else
   logic unused_ovf_clr;

   assign unused_ovf_clr = OVF_CLR;
   assign OVF            = 1'b0;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl (ADR_WIDTH=4) with a behavioural RAM,
// a vector table for cycle-exact cases and a scoreboard for streamed data.
module tb_ram_fifo_ctrl;
   localparam int DW = 8;
   localparam int AW = 4;

   logic          clk;
   logic          rst;
   logic          ovf_clr;
   logic [AW:0]   level;
   logic          ovf;
   logic          ram_wen;
   logic [AW-1:0] ram_wadr;
   logic [DW-1:0] ram_wdat;
   logic [AW-1:0] ram_radr;
   logic [DW-1:0] ram_rdat;
   logic [DW-1:0] mem [1<<AW];

   ram_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

   ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADR_WIDTH(AW)) dut (
      .CLK      (clk),
      .RST      (rst),
      .bus      (bus.slave),
      .LEVEL    (level),
      .OVF      (ovf),
      .OVF_CLR  (ovf_clr),
      .RAM_WEN  (ram_wen),
      .RAM_WADR (ram_wadr),
      .RAM_WDAT (ram_wdat),
      .RAM_RADR (ram_radr),
      .RAM_RDAT (ram_rdat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_wen) mem[ram_wadr] <= ram_wdat;
      ram_rdat <= mem[ram_radr];
   end

   int            n_vec = 0;
   int            n_err = 0;
   bit            sb_on = 1'b0;
   logic [DW-1:0] q [$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb_on && bus.RD_VALID && bus.RD_READY) begin
         n_vec++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL sb_extra got=%0h expected=none", bus.RD_DAT);
         end else begin
            logic [DW-1:0] e;
            e = q.pop_front();
            if (bus.RD_DAT !== e) begin
               n_err++;
               $display("FAIL sb_data got=%0h expected=%0h", bus.RD_DAT, e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.WR_REQ = 1'b0;
      bus.RD_READY = 1'b0;
      step();
      rst = 1'b0;
      q.delete();
   endtask

   task automatic wait_drained(input string name, input int budget);
      int c;
      c = 0;
      while (q.size() != 0 && c < budget) begin
         step();
         c++;
      end
      chk(name, q.size(), 0);
   endtask

   typedef struct {
      logic          rst;
      logic          wr;
      logic [DW-1:0] dat;
      logic          rdy;
      logic          e_vld;
      logic [DW-1:0] e_dat;
      logic [AW:0]   e_lvl;
      logic          e_full;
      logic          cd;
   } vec_t;

   vec_t tbl [13];

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int sent;
      int cyc;
      // rst wr dat rdy | vld dat lvl full check_dat
      tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1};
      tbl[1]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 5'd0, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 5'd0, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 5'd0, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hC3, 5'd0, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};

      rst = 1'b1;
      ovf_clr = 1'b0;
      bus.WR_REQ = 1'b0;
      bus.WR_DAT = '0;
      bus.RD_READY = 1'b0;
      step();
      step();

      for (int i = 0; i < 13; i++) begin
         logic [15:0] got;
         logic [15:0] exp;
         rst = tbl[i].rst;
         bus.WR_REQ = tbl[i].wr;
         bus.WR_DAT = tbl[i].dat;
         bus.RD_READY = tbl[i].rdy;
         step();
         got = {bus.RD_VALID, tbl[i].cd ? bus.RD_DAT : 8'h00, level, bus.WR_FULL, 1'b0};
         exp = {tbl[i].e_vld, tbl[i].cd ? tbl[i].e_dat : 8'h00, tbl[i].e_lvl, tbl[i].e_full, 1'b0};
         chk($sformatf("vec%0d", i), {16'h0, got}, {16'h0, exp});
      end

      sb_on = 1'b1;

      // Fill: RAM plus two prefetch words
      do_reset();
      for (int i = 0; i < 18; i++) begin
         bus.WR_REQ = 1'b1;
         bus.WR_DAT = 8'(i);
         q.push_back(8'(i));
         step();
         chk($sformatf("fill_full%0d", i), bus.WR_FULL, (i == 17) ? 1 : 0);
      end
      bus.WR_REQ = 1'b0;
      step();
      step();
      chk("fill_level", level, 16);
      chk("fill_head", {bus.RD_VALID, bus.RD_DAT}, {1'b1, 8'h00});
      bus.WR_REQ = 1'b1;
      bus.WR_DAT = 8'h99;
      #1;
      chk("drop_wen", ram_wen, 0);
      step();
      bus.WR_REQ = 1'b0;
      chk("drop_level", level, 16);
`ifdef RAM_FIFO_OVF_EN
      chk("ovf_set", ovf, 1);
      bus.WR_REQ = 1'b1;
      ovf_clr = 1'b1;
      step();
      chk("ovf_set_wins", ovf, 1);
      bus.WR_REQ = 1'b0;
      step();
      ovf_clr = 1'b0;
      chk("ovf_clear", ovf, 0);
`else
      chk("ovf_off", ovf, 0);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("ovf_off_clr", ovf, 0);
`endif

      // Drain: 18 back-to-back words
      bus.RD_READY = 1'b1;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         chk($sformatf("drain_vld%0d", i), bus.RD_VALID, 1);
      end
      @(negedge clk);
      chk("drain_end", {bus.RD_VALID, level}, 0);
      chk("drain_sb", q.size(), 0);
      @(posedge clk);
      #1;
      bus.RD_READY = 1'b0;

      // Simultaneous write and issue at LEVEL=5
      do_reset();
      for (int i = 0; i < 7; i++) begin
         bus.WR_REQ = 1'b1;
         bus.WR_DAT = 8'(8'h40 + i);
         q.push_back(8'(8'h40 + i));
         step();
      end
      bus.WR_REQ = 1'b0;
      step();
      step();
      step();
      chk("sim_level_pre", level, 5);
      bus.WR_REQ = 1'b1;
      bus.WR_DAT = 8'h47;
      bus.RD_READY = 1'b1;
      q.push_back(8'h47);
      step();
      bus.WR_REQ = 1'b0;
      bus.RD_READY = 1'b0;
      chk("sim_level_post", level, 5);
      bus.RD_READY = 1'b1;
      wait_drained("sim_drain", 40);
      step();
      bus.RD_READY = 1'b0;

      // Reset with words buffered and a read in flight
      do_reset();
      for (int i = 0; i < 12; i++) begin
         bus.WR_REQ = 1'b1;
         bus.WR_DAT = 8'(8'h80 + i);
         q.push_back(8'(8'h80 + i));
         step();
      end
      bus.WR_REQ = 1'b0;
      step();
      step();
      step();
      chk("rst_level_pre", level, 10);
      bus.RD_READY = 1'b1;
      step();
      bus.RD_READY = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      q.delete();
      chk("rst_mid", {bus.RD_VALID, level}, 0);
      bus.WR_REQ = 1'b1;
      bus.WR_DAT = 8'h3C;
      q.push_back(8'h3C);
      step();
      bus.WR_REQ = 1'b0;
      bus.RD_READY = 1'b1;
      wait_drained("rst_readback", 10);
      step();
      chk("rst_empty", {bus.RD_VALID, level}, 0);
      bus.RD_READY = 1'b0;

      // Streaming with random back-pressure across many pointer wraps
      do_reset();
      sent = 0;
      cyc = 0;
      while ((sent < 300 || q.size() != 0) && cyc < 5000) begin
         bus.RD_READY = 1'($urandom_range(0, 1));
         if (sent < 300 && q.size() < 14) begin
            bus.WR_REQ = 1'b1;
            bus.WR_DAT = 8'(sent);
            q.push_back(8'(sent));
            sent++;
         end else begin
            bus.WR_REQ = 1'b0;
         end
         step();
         cyc++;
      end
      bus.WR_REQ = 1'b0;
      bus.RD_READY = 1'b0;
      chk("stream_sent", sent, 300);
      chk("stream_left", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
